// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package run_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} run_state_e;

   localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
   localparam int          PASS_VALUE          = 1;

endpackage

// File: rtl/tohost_mon.sv
// Per-hart tohost watcher: first store to the mailbox halts the hart and
// records whether it reported pass (1) or a failure code (data >> 1).
module tohost_mon
   import run_ctrl_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_enable,
   input  logic            i_st_valid,
   input  logic [XLEN-1:0] i_st_addr,
   input  logic [XLEN-1:0] i_st_data,
   output logic            o_hit,
   output logic            o_fail_evt,
   output logic [XLEN-1:0] o_evt_code,
   output logic            o_halted,
   output logic            o_fail
);

   logic r_halted;
   logic r_fail;
   logic w_hit;
   logic w_pass;

   assign w_hit      = i_enable & i_st_valid & (i_st_addr == TOHOST_ADDR) & ~r_halted;
   assign w_pass     = (i_st_data == XLEN'(PASS_VALUE));
   assign o_hit      = w_hit;
   assign o_fail_evt = w_hit & ~w_pass;
   assign o_evt_code = i_st_data >> 1;
   assign o_halted   = r_halted;
   assign o_fail     = r_fail;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_halted <= 1'b0;
         r_fail   <= 1'b0;
      end else if (i_clear) begin
         r_halted <= 1'b0;
         r_fail   <= 1'b0;
      end else if (w_hit) begin
         r_halted <= 1'b1;
         r_fail   <= ~w_pass;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset, counts RUN cycles, collects tohost
// results per hart. Optional per-hart retire counters under RUN_CTRL_RETIRE_CNT_EN.
module cpu_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int              NUM_HARTS   = 1,
   parameter int              XLEN        = 32,
   parameter int              RST_CYCLES  = 2,
   parameter int              MAX_CYCLES  = 10000,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT),
   localparam int             CNT_W       = $clog2(MAX_CYCLES + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [NUM_HARTS-1:0]      i_st_valid,
   input  logic [NUM_HARTS*XLEN-1:0] i_st_addr,
   input  logic [NUM_HARTS*XLEN-1:0] i_st_data,
   input  logic [NUM_HARTS-1:0]      i_retire,
   output logic                      o_core_rst,
   output logic                      o_running,
   output logic                      o_done,
   output logic                      o_pass,
   output logic                      o_timeout,
   output logic [NUM_HARTS-1:0]      o_halted,
   output logic [XLEN-1:0]           o_exit_code,
`ifdef RUN_CTRL_RETIRE_CNT_EN
   output logic [NUM_HARTS*CNT_W-1:0] o_retired_cnt,
`endif
   output logic [CNT_W-1:0]          o_cycle_cnt
);

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_e                       r_state, w_next;
   logic [RCW-1:0]                   r_rst_cnt;
   logic [CNT_W-1:0]                 r_cycle_cnt;
   logic                             r_timeout;
   logic [XLEN-1:0]                  r_exit_code;
   logic                             w_start, w_run, w_rst_last, w_limit, w_all_halt, w_any_fail;
   logic [NUM_HARTS-1:0]             w_hit, w_fail_evt, w_halted, w_fail;
   logic [NUM_HARTS-1:0][XLEN-1:0]   w_evt_code;
   logic [XLEN-1:0]                  w_first_code;

   assign w_start    = i_start & ((r_state == IDLE) | (r_state == DONE));
   assign w_run      = (r_state == RUN);
   assign w_rst_last = (r_rst_cnt == RCW'(RST_CYCLES - 1));
   assign w_limit    = (r_cycle_cnt == CNT_W'(MAX_CYCLES));
   assign w_all_halt = &(w_halted | w_hit);
   assign w_any_fail = |w_fail;

   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_mon
      tohost_mon #(.XLEN(XLEN), .TOHOST_ADDR(TOHOST_ADDR)) u_mon (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_clear    (w_start),
         .i_enable   (w_run),
         .i_st_valid (i_st_valid[g]),
         .i_st_addr  (i_st_addr[g*XLEN +: XLEN]),
         .i_st_data  (i_st_data[g*XLEN +: XLEN]),
         .o_hit      (w_hit[g]),
         .o_fail_evt (w_fail_evt[g]),
         .o_evt_code (w_evt_code[g]),
         .o_halted   (w_halted[g]),
         .o_fail     (w_fail[g])
      );
   end

   // Lowest-index hart failing this cycle supplies the exit code.
   always_comb begin
      w_first_code = '0;
      for (int i = NUM_HARTS - 1; i >= 0; i--)
         if (w_fail_evt[i]) w_first_code = w_evt_code[i];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_next = RESET;
         RESET:   if (w_rst_last) w_next = RUN;
         RUN:     if (w_all_halt || w_limit) w_next = DONE;
         DONE:    if (i_start) w_next = RESET;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_core_rst  = ~w_run;
      o_running   = w_run;
      o_done      = (r_state == DONE);
      o_pass      = (r_state == DONE) & ~w_any_fail & ~r_timeout;
      o_timeout   = r_timeout;
      o_halted    = w_halted;
      o_exit_code = r_exit_code;
      o_cycle_cnt = r_cycle_cnt;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rst_cnt   <= '0;
         r_cycle_cnt <= '0;
         r_timeout   <= 1'b0;
         r_exit_code <= '0;
      end else begin
         r_rst_cnt <= ((r_state == RESET) && !w_rst_last) ? r_rst_cnt + RCW'(1) : '0;
         if (w_start) begin
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
            r_exit_code <= '0;
         end else begin
            if (w_run && !w_limit) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (w_run && w_limit)  r_timeout   <= 1'b1;
            if (!w_any_fail && |w_fail_evt) r_exit_code <= w_first_code;
         end
      end
   end

`ifdef RUN_CTRL_RETIRE_CNT_EN
   logic [NUM_HARTS-1:0][CNT_W-1:0] r_ret_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ret_cnt <= '0;
      end else if (w_start) begin
         r_ret_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_HARTS; i++)
            if (w_run && i_retire[i] && !w_halted[i] && (r_ret_cnt[i] != '1))
               r_ret_cnt[i] <= r_ret_cnt[i] + CNT_W'(1);
      end
   end

   assign o_retired_cnt = r_ret_cnt;
`else
   logic w_unused_retire;
   assign w_unused_retire = ^i_retire;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: per-run expectations come from a
// schedule-level model; a monitor checks them whenever done rises.
module tb_cpu_run_ctrl;

   localparam int          NH   = 2;
   localparam int          XL   = 32;
   localparam int          RC   = 2;
   localparam int          MC   = 100;
   localparam int          CW   = $clog2(MC + 1);
   localparam int          NONE = 100000;
   localparam logic [31:0] TH   = 32'h0000_1000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [NH-1:0]    st_valid = '0;
   logic [NH-1:0]    retire = '0;
   logic [NH*XL-1:0] st_addr = '0;
   logic [NH*XL-1:0] st_data = '0;
   logic             core_rst, running, done, pass, timeout;
   logic [NH-1:0]    halted;
   logic [XL-1:0]    exit_code;
   logic [CW-1:0]    cycle_cnt;
`ifdef RUN_CTRL_RETIRE_CNT_EN
   logic [NH*CW-1:0] retired_cnt;
`endif

   cpu_run_ctrl #(
      .NUM_HARTS(NH), .XLEN(XL), .RST_CYCLES(RC), .MAX_CYCLES(MC), .TOHOST_ADDR(TH)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_st_valid(st_valid), .i_st_addr(st_addr), .i_st_data(st_data), .i_retire(retire),
      .o_core_rst(core_rst), .o_running(running), .o_done(done), .o_pass(pass),
      .o_timeout(timeout), .o_halted(halted), .o_exit_code(exit_code),
`ifdef RUN_CTRL_RETIRE_CNT_EN
      .o_retired_cnt(retired_cnt),
`endif
      .o_cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NH-1:0]         halted;
      logic                  pass;
      logic                  timeout;
      logic [XL-1:0]         exit_code;
      logic [CW-1:0]         cnt;
      logic [NH-1:0][CW-1:0] ret;
   } exp_t;

   exp_t          q[$];
   exp_t          e;
   int            n_chk = 0;
   int            n_fail = 0;
   logic          prev_done = 1'b0;

   // Run schedule: hart h writes d[h] to tohost in RUN cycle c[h] (NONE = never).
   int            c[NH];
   logic [XL-1:0] d[NH];
   bit            rt[NH][MC+4];
   bit            abort;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_core_rst"}, core_rst, 1);
      chk({tag, "_running"}, running, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_exit"}, exit_code, 0);
      chk({tag, "_cnt"}, cycle_cnt, 0);
`ifdef RUN_CTRL_RETIRE_CNT_EN
      chk({tag, "_retired"}, retired_cnt, 0);
`endif
   endtask

   // Reference: run ends in the cycle of the last halt or at the limit.
   task automatic push_expect();
      exp_t x;
      int   t_last, k_end, best;
      t_last = 0;
      for (int h = 0; h < NH; h++) if (c[h] > t_last) t_last = c[h];
      k_end = (t_last < MC) ? t_last : MC;
      x = '0;
      x.cnt     = CW'((k_end + 1 < MC) ? k_end + 1 : MC);
      x.timeout = (t_last >= MC);
      best = -1;
      for (int h = 0; h < NH; h++) begin
         int lim, s;
         x.halted[h] = (c[h] <= k_end);
         if (x.halted[h] && d[h] != 1 && (best < 0 || c[h] < c[best])) best = h;
         lim = (c[h] < k_end) ? c[h] : k_end;
         s = 0;
         for (int k = 0; k <= lim; k++) s += int'(rt[h][k]);
         x.ret[h] = CW'(s);
      end
      x.exit_code = (best < 0) ? '0 : d[best] >> 1;
      x.pass      = (best < 0) && !x.timeout;
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (rst_n && done && !prev_done) begin
         if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb_empty: done rose with no expectation queued (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            chk("done_halted", halted, e.halted);
            chk("done_pass", pass, e.pass);
            chk("done_timeout", timeout, e.timeout);
            chk("done_exit", exit_code, e.exit_code);
            chk("done_cnt", cycle_cnt, e.cnt);
            chk("done_core_rst", core_rst, 1);
            chk("done_running", running, 0);
`ifdef RUN_CTRL_RETIRE_CNT_EN
            for (int h = 0; h < NH; h++)
               chk("done_retired", retired_cnt[h*CW +: CW], e.ret[h]);
`endif
         end
      end
      prev_done <= done;
   end

   task automatic drive_cycle(input int k);
      for (int h = 0; h < NH; h++) begin
         logic [XL-1:0] a, v;
         logic          vl;
         vl = ($urandom_range(0, 2) == 0);
         a  = TH ^ (32'h1 << $urandom_range(0, 31));
         v  = $urandom;
         if (k == c[h]) begin
            vl = 1'b1; a = TH; v = d[h];
         end else if (k > c[h] && $urandom_range(0, 1) == 1) begin
            a = TH;
         end
         st_valid[h]          = vl;
         st_addr[h*XL +: XL]  = a;
         st_data[h*XL +: XL]  = v;
         retire[h]            = (k < MC + 4) ? rt[h][k] : 1'b0;
      end
      start = ($urandom_range(0, 15) == 0);
   endtask

   task automatic idle_inputs();
      st_valid = '0; st_addr = '0; st_data = '0; retire = '0; start = 1'b0;
   endtask

   task automatic do_run();
      int cnt;
      bit got_done;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("rst_core_rst", core_rst, 1);
      chk("rst_halted_clr", halted, 0);
      chk("rst_done_clr", done, 0);
      cnt = 0;
      while (!running && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      chk("rst_len", cnt, RC);
      chk("run_core_rst", core_rst, 0);
      got_done = 0;
      for (int k = 0; k <= MC + 3; k++) begin
         if (done) begin
            got_done = 1;
            break;
         end
         chk("run_cnt", cycle_cnt, k);
         if (abort && k == 20) begin
            rst_n = 1'b0;
            #1;
            chk_idle("abort");
            @(negedge clk);
            idle_inputs();
            rst_n = 1'b1;
            return;
         end
         drive_cycle(k);
         @(negedge clk);
      end
      idle_inputs();
      if (!got_done) begin
         n_chk++; n_fail++;
         $display("FAIL run_end: done never rose within %0d cycles", MC + 4);
      end
   endtask

   task automatic setup(input int r);
      abort = 0;
      for (int h = 0; h < NH; h++) begin
         c[h] = NONE;
         d[h] = 1;
         for (int k = 0; k < MC + 4; k++) rt[h][k] = ($urandom_range(0, 1) == 1);
      end
      case (r)
         0: begin c[0] = 10; d[0] = 1; c[1] = 10; d[1] = 7; end
         1: begin c[0] = 50; c[1] = 20; end
         2: begin c[0] = 30; end
         3: begin c[0] = 40; c[1] = 100; end
         4: begin c[0] = 99; c[1] = 3; d[1] = 5; end
         5: begin c[0] = 5; d[0] = 9; abort = 1; end
         6: begin c[0] = 0; d[0] = 0; c[1] = 0; d[1] = 4; end
         default: begin
            for (int h = 0; h < NH; h++) begin
               c[h] = ($urandom_range(0, 7) == 0) ? NONE : int'($urandom_range(0, 110));
               d[h] = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
            end
         end
      endcase
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_idle("por");
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_core_rst", core_rst, 1);
      chk("idle_running", running, 0);
      for (int r = 0; r < 16; r++) begin
         setup(r);
         if (!abort) push_expect();
         do_run();
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: %0d expectations never matched", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
